// File: rtl/pcpi_serial_bridge.sv
// pcpi_serial_bridge: narrow serial front end for a PCPI coprocessor.
// It assembles an XLEN-bit instruction from SEG_W-bit segments, issues it
// over PCPI with a watchdog, and streams any write-back result out in segments.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_LOAD  | accepting instruction segments, LSB segment first
// S_ISSUE | pcpi_valid held high, waiting for pcpi_ready or watchdog expiry
// S_DRAIN | streaming the latched result out, one segment per res_ack
module pcpi_serial_bridge #(
    parameter int SEG_W   = 4,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] seg_in,
    input  logic             seg_valid,
    output logic             seg_ready,
    output logic             pcpi_valid,
    output logic [XLEN-1:0]  pcpi_insn,
    input  logic             pcpi_ready,
    input  logic             pcpi_wr,
    input  logic [XLEN-1:0]  pcpi_rd,
    input  logic             pcpi_wait,
    output logic [SEG_W-1:0] res_seg,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             busy,
    output logic             timeout_err
);

    localparam int NSEG      = XLEN / SEG_W;
    localparam int IDX_W     = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit WD_EN     = (TIMEOUT != 0);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSEG - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_LAST_I);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                      state;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            ridx;
    logic [WD_W-1:0]             wdog;
    logic [NSEG-1:0][SEG_W-1:0]  insn_r;
    logic [NSEG-1:0][SEG_W-1:0]  result_r;

    // Outputs decoded from state; seg_ready is additionally masked by reset
    // so no segment appears accepted while the bridge is held in reset.
    assign seg_ready = rst_n & (state == S_LOAD);
    assign busy      = (state != S_LOAD);
    assign res_valid = (state == S_DRAIN);
    assign res_seg   = result_r[ridx];
    assign pcpi_insn = insn_r;

    // Control FSM: segment index, issue watchdog, drain index and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            idx         <= '0;
            ridx        <= '0;
            wdog        <= '0;
            pcpi_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (seg_valid) begin
                        if (idx == '0)
                            timeout_err <= 1'b0;
                        if (idx == IDX_LAST) begin
                            idx        <= '0;
                            wdog       <= '0;
                            pcpi_valid <= 1'b1;
                            state      <= S_ISSUE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    // A coprocessor response beats a simultaneous expiry.
                    if (pcpi_ready) begin
                        pcpi_valid <= 1'b0;
                        ridx       <= '0;
                        state      <= pcpi_wr ? S_DRAIN : S_LOAD;
                    end else if (WD_EN && !pcpi_wait) begin
                        if (wdog == WD_LAST) begin
                            pcpi_valid  <= 1'b0;
                            timeout_err <= 1'b1;
                            state       <= S_LOAD;
                        end else begin
                            wdog <= wdog + WD_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (res_ack) begin
                        if (ridx == IDX_LAST) begin
                            ridx  <= '0;
                            state <= S_LOAD;
                        end else begin
                            ridx <= ridx + IDX_W'(1);
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // Datapath registers: instruction and result are intentionally not reset.
    always_ff @(posedge clk) begin
        if (rst_n && state == S_LOAD && seg_valid)
            insn_r[idx] <= seg_in;
        if (rst_n && state == S_ISSUE && pcpi_ready && pcpi_wr)
            result_r <= pcpi_rd;
    end

endmodule

// File: tb/tb_pcpi_serial_bridge.sv
// Directed bench for pcpi_serial_bridge: a 4-bit/TIMEOUT=8 instance for the
// main flows and an 8-bit segment instance for the wide-segment case.
module tb_pcpi_serial_bridge;

    logic        clk;
    logic        rst_n;

    logic [3:0]  seg_in;
    logic        seg_valid;
    logic        seg_ready;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic        pcpi_ready;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic [3:0]  res_seg;
    logic        res_valid;
    logic        res_ack;
    logic        busy;
    logic        timeout_err;

    logic [7:0]  b_seg_in;
    logic        b_seg_valid;
    logic        b_seg_ready;
    logic        b_pcpi_valid;
    logic [31:0] b_pcpi_insn;
    logic        b_pcpi_ready;
    logic        b_pcpi_wr;
    logic [31:0] b_pcpi_rd;
    logic        b_pcpi_wait;
    logic [7:0]  b_res_seg;
    logic        b_res_valid;
    logic        b_res_ack;
    logic        b_busy;
    logic        b_timeout_err;

    int checks = 0;
    int errors = 0;

    pcpi_serial_bridge #(.SEG_W(4), .XLEN(32), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .seg_in(seg_in), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait),
        .res_seg(res_seg), .res_valid(res_valid), .res_ack(res_ack),
        .busy(busy), .timeout_err(timeout_err)
    );

    pcpi_serial_bridge #(.SEG_W(8), .XLEN(32), .TIMEOUT(255)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .seg_in(b_seg_in), .seg_valid(b_seg_valid), .seg_ready(b_seg_ready),
        .pcpi_valid(b_pcpi_valid), .pcpi_insn(b_pcpi_insn),
        .pcpi_ready(b_pcpi_ready), .pcpi_wr(b_pcpi_wr), .pcpi_rd(b_pcpi_rd),
        .pcpi_wait(b_pcpi_wait),
        .res_seg(b_res_seg), .res_valid(b_res_valid), .res_ack(b_res_ack),
        .busy(b_busy), .timeout_err(b_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loads one word LSB nibble first, one segment per cycle.
    task automatic load_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_seg_ready[%0d]: got %b expected 1", i, seg_ready);
            end
            seg_in    = w[i*4 +: 4];
            seg_valid = 1'b1;
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (timeout_err !== 1'b0) begin
                    errors++;
                    $display("FAIL load_err_clear: got %b expected 0", timeout_err);
                end
            end
            if (i == 6) begin
                checks++;
                if (pcpi_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL load_valid_early: got %b expected 0", pcpi_valid);
                end
            end
        end
        seg_valid = 1'b0;
        checks++;
        if (pcpi_valid !== 1'b1 || pcpi_insn !== w) begin
            errors++;
            $display("FAIL load_issue: valid %b insn %h expected 1 %h", pcpi_valid, pcpi_insn, w);
        end
        checks++;
        if (seg_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy: seg_ready %b busy %b expected 0 1", seg_ready, busy);
        end
    endtask

    task automatic respond(input logic wr, input logic [31:0] rd);
        pcpi_ready = 1'b1;
        pcpi_wr    = wr;
        pcpi_rd    = rd;
        @(negedge clk);
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        checks++;
        if (pcpi_valid !== 1'b0 || res_valid !== wr) begin
            errors++;
            $display("FAIL respond: pcpi_valid %b res_valid %b expected 0 %b", pcpi_valid, res_valid, wr);
        end
        if (wr) begin
            checks++;
            if (res_seg !== rd[3:0]) begin
                errors++;
                $display("FAIL respond_seg0: got %h expected %h", res_seg, rd[3:0]);
            end
        end else begin
            checks++;
            if (seg_ready !== 1'b1) begin
                errors++;
                $display("FAIL respond_load: seg_ready %b expected 1", seg_ready);
            end
        end
    endtask

    task automatic drain_check(input logic [31:0] rd, input bit gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps) begin
                res_ack = 1'b0;
                @(negedge clk);
                checks++;
                if (res_valid !== 1'b1 || res_seg !== rd[k*4 +: 4]) begin
                    errors++;
                    $display("FAIL drain_hold[%0d]: valid %b seg %h expected 1 %h", k, res_valid, res_seg, rd[k*4 +: 4]);
                end
            end
            checks++;
            if (res_valid !== 1'b1 || res_seg !== rd[k*4 +: 4]) begin
                errors++;
                $display("FAIL drain_seg[%0d]: valid %b seg %h expected 1 %h", k, res_valid, res_seg, rd[k*4 +: 4]);
            end
            res_ack = 1'b1;
            @(negedge clk);
        end
        res_ack = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || seg_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_done: res_valid %b seg_ready %b expected 0 1", res_valid, seg_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (seg_ready !== 1'b0 || pcpi_valid !== 1'b0 || res_valid !== 1'b0 ||
            busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: rdy %b pv %b rv %b busy %b err %b expected all 0",
                     tag, seg_ready, pcpi_valid, res_valid, busy, timeout_err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        seg_valid = 1'b1;
        seg_in = 4'hF;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_values");
        seg_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (seg_ready !== 1'b1 || b_seg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: seg_ready %b %b expected 1 1", seg_ready, b_seg_ready);
        end
    endtask

    task automatic test_issue_drain;
        load_word(32'h020000B3);
        seg_in = 4'hF;
        seg_valid = 1'b1;
        repeat (3) @(negedge clk);
        seg_valid = 1'b0;
        checks++;
        if (pcpi_valid !== 1'b1 || pcpi_insn !== 32'h020000B3 || seg_ready !== 1'b0) begin
            errors++;
            $display("FAIL issue_hold: pv %b insn %h rdy %b expected 1 020000b3 0", pcpi_valid, pcpi_insn, seg_ready);
        end
        respond(1'b1, 32'hDEADBEEF);
        drain_check(32'hDEADBEEF, 1'b1);
    endtask

    task automatic test_no_write;
        load_word(32'h00A00093);
        respond(1'b0, 32'h55555555);
        load_word(32'h12345678);
        respond(1'b1, 32'h89ABCDEF);
        drain_check(32'h89ABCDEF, 1'b0);
    endtask

    task automatic test_timeout;
        int cnt;
        load_word(32'h00000013);
        cnt = 0;
        while (pcpi_valid === 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != 8 || timeout_err !== 1'b1 || seg_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_plain: cycles %0d err %b rdy %b expected 8 1 1", cnt, timeout_err, seg_ready);
        end
        load_word(32'h00100093);
        cnt = 0;
        while (pcpi_valid === 1'b1 && cnt < 50) begin
            pcpi_wait = (cnt >= 2 && cnt < 7);
            @(negedge clk);
            cnt++;
        end
        pcpi_wait = 1'b0;
        checks++;
        if (cnt != 13 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_wait: cycles %0d err %b expected 13 1", cnt, timeout_err);
        end
        load_word(32'h00200093);
        repeat (7) @(negedge clk);
        checks++;
        if (pcpi_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pre_expiry: pv %b expected 1", pcpi_valid);
        end
        respond(1'b0, 32'h0);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ready_wins: err %b expected 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            seg_in = 4'hF;
            seg_valid = 1'b1;
            @(negedge clk);
        end
        seg_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_load");
        rst_n = 1'b1;
        #1;
        load_word(32'h020000B3);
        respond(1'b1, 32'h13572468);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        checks++;
        if (res_seg !== 4'h6 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_seg1: seg %h valid %b expected 6 1", res_seg, res_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_drain");
        rst_n = 1'b1;
        #1;
        load_word(32'hCAFE0013);
        respond(1'b0, 32'h0);
    endtask

    task automatic test_seg8;
        logic [31:0] w;
        logic [31:0] rd;
        w = 32'h00100513;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_seg_ready !== 1'b1) begin
                errors++;
                $display("FAIL seg8_ready[%0d]: got %b expected 1", i, b_seg_ready);
            end
            b_seg_in = w[i*8 +: 8];
            b_seg_valid = 1'b1;
            @(negedge clk);
        end
        b_seg_in = 8'hFF;
        checks++;
        if (b_pcpi_valid !== 1'b1 || b_pcpi_insn !== 32'h00100513 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL seg8_issue: pv %b insn %h busy %b expected 1 00100513 1", b_pcpi_valid, b_pcpi_insn, b_busy);
        end
        repeat (3) @(negedge clk);
        b_seg_valid = 1'b0;
        checks++;
        if (b_seg_ready !== 1'b0 || b_pcpi_insn !== 32'h00100513) begin
            errors++;
            $display("FAIL seg8_ignore: rdy %b insn %h expected 0 00100513", b_seg_ready, b_pcpi_insn);
        end
        rd = 32'hA1B2C3D4;
        b_pcpi_ready = 1'b1;
        b_pcpi_wr = 1'b1;
        b_pcpi_rd = rd;
        @(negedge clk);
        b_pcpi_ready = 1'b0;
        b_pcpi_wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (b_res_valid !== 1'b1 || b_res_seg !== rd[k*8 +: 8]) begin
                errors++;
                $display("FAIL seg8_drain[%0d]: valid %b seg %h expected 1 %h", k, b_res_valid, b_res_seg, rd[k*8 +: 8]);
            end
            b_res_ack = 1'b1;
            @(negedge clk);
        end
        b_res_ack = 1'b0;
        w = 32'hAABBCCDD;
        for (int i = 0; i < 4; i++) begin
            b_seg_in = w[i*8 +: 8];
            b_seg_valid = 1'b1;
            @(negedge clk);
        end
        b_seg_valid = 1'b0;
        checks++;
        if (b_pcpi_valid !== 1'b1 || b_pcpi_insn !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL seg8_reload: pv %b insn %h expected 1 aabbccdd", b_pcpi_valid, b_pcpi_insn);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        seg_in = '0; seg_valid = 1'b0;
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0;
        res_ack = 1'b0;
        b_seg_in = '0; b_seg_valid = 1'b0;
        b_pcpi_ready = 1'b0; b_pcpi_wr = 1'b0; b_pcpi_rd = '0; b_pcpi_wait = 1'b0;
        b_res_ack = 1'b0;
        @(negedge clk);
        test_reset;
        test_issue_drain;
        test_no_write;
        test_timeout;
        test_reset_mid;
        test_seg8;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
